decode_writeback: RTL and testbench
===================================

Name: decode_writeback

Overview:
- Y86-64 sequential-processor decode and write-back stage, directly downstream of fetch.
- Consumes icode, rA and rB from fetch, and derives the source and destination register IDs.
- Reads valA and valB combinationally from a 15-entry x 64-bit register file.
- Commits the execute result (valE) and the memory result (valM) into the register file on the rising clock edge.

Parameters:
- NREGS, 15, number of architectural registers (IDs 0x0-0xE; ID 0xF means "none").
- WIDTH, 64, register data width.
- RSP_ID, 4, register ID of %rsp.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- icode  input  4  instruction code from fetch.
- rA  input  4  register A field from fetch.
- rB  input  4  register B field from fetch.
- cnd  input  1  condition flag from execute; gates the cmovXX write.
- valE  input  WIDTH  ALU result to write back.
- valM  input  WIDTH  memory read result to write back.
- wb_en  input  1  write-back enable; when 0, no register is written this cycle.
- srcA  output  4  decoded source A register ID.
- srcB  output  4  decoded source B register ID.
- dstE  output  4  decoded E-port destination register ID.
- dstM  output  4  decoded M-port destination register ID.
- valA  output  WIDTH  register file read of srcA.
- valB  output  WIDTH  register file read of srcB.
- dbg_addr  input  4  debug read address.
- dbg_data  output  WIDTH  debug read of register dbg_addr.

Behaviour:
- Reset (async, rst=1): all 15 registers are cleared to 0 immediately, independent of clk.
  - srcA, srcB, dstE, dstM, valA, valB and dbg_data follow combinationally from the inputs and the now-zero register file.
  - Writes are blocked while rst=1.
- srcA decode (combinational):
  - icode 2, 4, 6, 0xA -> rA.
  - icode 9, 0xB -> RSP_ID.
  - otherwise 0xF.
- srcB decode:
  - icode 4, 5, 6 -> rB.
  - icode 8, 9, 0xA, 0xB -> RSP_ID.
  - otherwise 0xF.
- dstE decode:
  - icode 2 -> rB when cnd=1, else 0xF.
  - icode 3, 6 -> rB.
  - icode 8, 9, 0xA, 0xB -> RSP_ID.
  - otherwise 0xF.
- dstM decode:
  - icode 5, 0xB -> rA.
  - otherwise 0xF.
- Undefined icodes (0xC-0xF) decode all four IDs to 0xF.
- Register read (combinational):
  - valA = reg[srcA] and valB = reg[srcB].
  - Any read of ID 0xF returns 0.
  - dbg_data follows the same rule for dbg_addr.
- Register write (rising edge of clk, only when rst=0 and wb_en=1):
  - reg[dstE] <= valE if dstE != 0xF.
  - reg[dstM] <= valM if dstM != 0xF.
- Same-edge conflict: if dstE == dstM != 0xF (popq %rsp), valM wins and valE is discarded.
- Read-during-write: valA and valB show the pre-edge value until the edge. The new value appears after the edge. There is no internal bypass.
- Latency: decode and read are 0 cycles (combinational). A write becomes visible 1 cycle later.
- Reset asserted mid-cycle overrides any pending write. A write on the edge where rst deasserts is performed only if rst is already low at that edge.

Test Plan:
- Reset: assert rst, then release. For dbg_addr 0..14, dbg_data=0. dbg_addr=0xF -> 0.
- irmovq: icode=3, rB=2, valE=0x1234, wb_en=1, one edge.
  - dstE=2 and dstM=0xF.
  - Afterwards dbg_addr=2 reads 0x1234. icode=6, rA=2, rB=2 then gives valA=valB=0x1234.
- cmovXX gating: icode=2, rA=2, rB=3.
  - cnd=0 -> dstE=0xF, and after the edge reg3 is unchanged (0).
  - cnd=1 with valE=0x55 -> reg3=0x55 after the edge.
- pushq / popq %rsp:
  - icode=0xA, rA=2 -> srcA=2, srcB=4, dstE=4.
  - icode=0xB, rA=4 with valE=0x100 and valM=0xBEEF -> after the edge reg4=0xBEEF (M wins).
- wb_en and async reset:
  - wb_en=0 with icode=3, rB=5, valE=0xFF -> after the edge reg5 stays 0.
  - Write reg5=0xFF, then pulse rst between edges -> reg5 reads 0 before the next edge.
- Undefined icode: icode=0xD -> srcA=srcB=dstE=dstM=0xF, valA=valB=0, and no write on the edge.

Source files
------------

// File: rtl/decode_writeback.sv
// -----------------------------------------------------------------------------
// decode_writeback
//
// Decode and write-back stage of a sequential Y86-64 processor. It sits
// directly after fetch. It turns icode/rA/rB into the four register IDs the
// instruction uses, reads valA/valB combinationally from the register file,
// and on the rising clock edge commits valE and valM into the register file.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   icode, rA, rB     instruction fields from fetch
//   cnd               condition flag from execute (gates the cmovXX write)
//   valE, valM        ALU result and memory result to write back
//   wb_en             write-back enable for this cycle
//   srcA, srcB        decoded source register IDs
//   dstE, dstM        decoded destination register IDs
//   valA, valB        register file reads of srcA / srcB (0 for ID 0xF)
//   dbg_addr/dbg_data debug read port, same read rule as valA/valB
//
// Reads are combinational and have no write bypass. A value written on an
// edge becomes visible only after that edge. Reset clears every register
// immediately, without waiting for a clock edge, and blocks writes while high.
// -----------------------------------------------------------------------------
module decode_writeback #(
   parameter int NREGS  = 15,
   parameter int WIDTH  = 64,
   parameter int RSP_ID = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       icode,
   input  logic [3:0]       rA,
   input  logic [3:0]       rB,
   input  logic             cnd,
   input  logic [WIDTH-1:0] valE,
   input  logic [WIDTH-1:0] valM,
   input  logic             wb_en,
   output logic [3:0]       srcA,
   output logic [3:0]       srcB,
   output logic [3:0]       dstE,
   output logic [3:0]       dstM,
   output logic [WIDTH-1:0] valA,
   output logic [WIDTH-1:0] valB,
   input  logic [3:0]       dbg_addr,
   output logic [WIDTH-1:0] dbg_data
);

   localparam logic [3:0] RNONE = 4'hF;
   localparam logic [3:0] RSP   = 4'(RSP_ID);

   logic [WIDTH-1:0] regs [NREGS];

   // An ID names a real register only if it is not 0xF and lies inside the file.
   function automatic logic id_valid(input logic [3:0] id);
      return (id != RNONE) && (int'(id) < NREGS);
   endfunction

   function automatic logic [WIDTH-1:0] rd(input logic [3:0] id);
      if (id_valid(id)) return regs[id];
      return '0;
   endfunction

   // Register ID decode. Any icode not listed here, including the undefined
   // 0xC-0xF range, leaves all four IDs at 0xF.
   always_comb begin
      srcA = RNONE;
      srcB = RNONE;
      dstE = RNONE;
      dstM = RNONE;
      case (icode)
         4'h2: begin                       // rrmovq / cmovXX
            srcA = rA;
            dstE = cnd ? rB : RNONE;
         end
         4'h3: dstE = rB;                  // irmovq
         4'h4: begin                       // rmmovq
            srcA = rA;
            srcB = rB;
         end
         4'h5: begin                       // mrmovq
            srcB = rB;
            dstM = rA;
         end
         4'h6: begin                       // OPq
            srcA = rA;
            srcB = rB;
            dstE = rB;
         end
         4'h8: begin                       // call
            srcB = RSP;
            dstE = RSP;
         end
         4'h9: begin                       // ret
            srcA = RSP;
            srcB = RSP;
            dstE = RSP;
         end
         4'hA: begin                       // pushq
            srcA = rA;
            srcB = RSP;
            dstE = RSP;
         end
         4'hB: begin                       // popq
            srcA = RSP;
            srcB = RSP;
            dstE = RSP;
            dstM = rA;
         end
         default: ;
      endcase
   end

   assign valA     = rd(srcA);
   assign valB     = rd(srcB);
   assign dbg_data = rd(dbg_addr);

   // The M write comes after the E write, so when both target the same
   // register (popq %rsp) the later nonblocking assignment makes valM win.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wb_en) begin
         if (id_valid(dstE)) regs[dstE] <= valE;
         if (id_valid(dstM)) regs[dstM] <= valM;
      end
   end

endmodule

// File: tb/tb_decode_writeback.sv
// -----------------------------------------------------------------------------
// tb_decode_writeback
//
// Bench for decode_writeback. A reference register file model plus decode
// tables produce the expected values. Each expectation is pushed to exp_q
// when its stimulus is driven, then popped and compared once the DUT output
// has settled. Inputs change 1 ns after a rising edge, and outputs are
// sampled before the next rising edge.
// -----------------------------------------------------------------------------
module tb_decode_writeback;

   localparam int W = 64;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT ----------------
   logic [3:0]   icode, ra, rb, dbg_addr;
   logic         cnd, wb_en;
   logic [W-1:0] vale, valm;
   logic [3:0]   srca, srcb, dste, dstm;
   logic [W-1:0] vala, valb, dbg_data;

   decode_writeback #(.NREGS(15), .WIDTH(W), .RSP_ID(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .icode    (icode),
      .rA       (ra),
      .rB       (rb),
      .cnd      (cnd),
      .valE     (vale),
      .valM     (valm),
      .wb_en    (wb_en),
      .srcA     (srca),
      .srcB     (srcb),
      .dstE     (dste),
      .dstM     (dstm),
      .valA     (vala),
      .valB     (valb),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   logic [W-1:0] model [15];
   int           n_checks = 0;
   int           n_pass   = 0;

   // Reference decode tables, taken from the Y86-64 SEQ stage definition.
   function automatic logic [3:0] m_srca(input logic [3:0] ic, input logic [3:0] a);
      case (ic)
         4'h2, 4'h4, 4'h6, 4'hA: return a;
         4'h9, 4'hB:             return 4'h4;
         default:                return 4'hF;
      endcase
   endfunction

   function automatic logic [3:0] m_srcb(input logic [3:0] ic, input logic [3:0] b);
      case (ic)
         4'h4, 4'h5, 4'h6:       return b;
         4'h8, 4'h9, 4'hA, 4'hB: return 4'h4;
         default:                return 4'hF;
      endcase
   endfunction

   function automatic logic [3:0] m_dste(input logic [3:0] ic, input logic [3:0] b,
                                         input logic c);
      case (ic)
         4'h2:                   return c ? b : 4'hF;
         4'h3, 4'h6:             return b;
         4'h8, 4'h9, 4'hA, 4'hB: return 4'h4;
         default:                return 4'hF;
      endcase
   endfunction

   function automatic logic [3:0] m_dstm(input logic [3:0] ic, input logic [3:0] a);
      return (ic == 4'h5 || ic == 4'hB) ? a : 4'hF;
   endfunction

   function automatic logic [W-1:0] m_read(input logic [3:0] id);
      return (id == 4'hF) ? '0 : model[id];
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                        input logic c, input logic wb, input logic [W-1:0] e,
                        input logic [W-1:0] m);
      icode = ic; ra = a; rb = b; cnd = c; wb_en = wb; vale = e; valm = m;
   endtask

   // Commit the write the current inputs imply to the model, then take one edge.
   task automatic step_commit();
      logic [3:0] de, dm;
      de = m_dste(icode, rb, cnd);
      dm = m_dstm(icode, ra);
      if (wb_en && !rst) begin
         if (de != 4'hF) model[de] = vale;
         if (dm != 4'hF) model[dm] = valm;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 15; i++) model[i] = '0;
   endtask

   // Queue the six decode/read expectations for the current inputs.
   task automatic push_decode();
      exp_q.push_back(W'(m_srca(icode, ra)));
      exp_q.push_back(W'(m_srcb(icode, rb)));
      exp_q.push_back(W'(m_dste(icode, rb, cnd)));
      exp_q.push_back(W'(m_dstm(icode, ra)));
      exp_q.push_back(m_read(m_srca(icode, ra)));
      exp_q.push_back(m_read(m_srcb(icode, rb)));
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [W-1:0] e;
      drive(4'h0, 4'hF, 4'hF, 1'b0, 1'b0, '0, '0);
      dbg_addr = 4'h0;
      #1 rst = 1'b1;
      model_clear();
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 16; i++) begin
         dbg_addr = 4'(i);
         exp_q.push_back('0);
         #1;
         e = exp_q.pop_front();
         n_checks++;
         if (dbg_data !== e) $display("FAIL reset_reg%0d: got %h expected %h", i, dbg_data, e);
         else n_pass++;
      end
   endtask

   task automatic test_decode_block(input string tag);
      logic [W-1:0] obs [6];
      string        nm  [6];
      logic [W-1:0] e;
      nm = '{"srcA", "srcB", "dstE", "dstM", "valA", "valB"};
      #1;
      obs[0] = W'(srca); obs[1] = W'(srcb); obs[2] = W'(dste); obs[3] = W'(dstm);
      obs[4] = vala;     obs[5] = valb;
      for (int k = 0; k < 6; k++) begin
         e = exp_q.pop_front();
         n_checks++;
         if (obs[k] !== e) $display("FAIL %s_%s: got %h expected %h", tag, nm[k], obs[k], e);
         else n_pass++;
      end
   endtask

   task automatic test_dbg(input string tag, input logic [3:0] addr);
      logic [W-1:0] e;
      dbg_addr = addr;
      exp_q.push_back(m_read(addr));
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (dbg_data !== e) $display("FAIL %s_reg%0d: got %h expected %h", tag, addr, dbg_data, e);
      else n_pass++;
   endtask

   task automatic test_irmovq();
      drive(4'h3, 4'hF, 4'h2, 1'b0, 1'b1, 64'h1234, 64'h0);
      push_decode();
      test_decode_block("irmovq");
      step_commit();
      wb_en = 1'b0;
      test_dbg("irmovq", 4'h2);
      drive(4'h6, 4'h2, 4'h2, 1'b0, 1'b0, '0, '0);
      push_decode();
      test_decode_block("opq_read");
   endtask

   task automatic test_cmov();
      drive(4'h2, 4'h2, 4'h3, 1'b0, 1'b1, 64'h77, '0);
      push_decode();
      test_decode_block("cmov_nc");
      step_commit();
      test_dbg("cmov_nc", 4'h3);
      drive(4'h2, 4'h2, 4'h3, 1'b1, 1'b1, 64'h55, '0);
      push_decode();
      test_decode_block("cmov_c");
      step_commit();
      wb_en = 1'b0;
      test_dbg("cmov_c", 4'h3);
   endtask

   task automatic test_push_pop();
      drive(4'hA, 4'h2, 4'hF, 1'b0, 1'b0, '0, '0);
      push_decode();
      test_decode_block("pushq");
      drive(4'hB, 4'h4, 4'hF, 1'b0, 1'b1, 64'h100, 64'hBEEF);
      push_decode();
      test_decode_block("popq_rsp");
      step_commit();
      wb_en = 1'b0;
      test_dbg("popq_rsp", 4'h4);
   endtask

   task automatic test_wb_en_and_reset();
      drive(4'h3, 4'hF, 4'h5, 1'b0, 1'b0, 64'hFF, '0);
      step_commit();
      test_dbg("wb_off", 4'h5);
      wb_en = 1'b1;
      step_commit();
      wb_en = 1'b0;
      test_dbg("wb_on", 4'h5);
      // Pulse reset between edges; the clear must show before the next edge.
      #1 rst = 1'b1;
      model_clear();
      test_dbg("async_rst", 4'h5);
      #1 rst = 1'b0;
      test_dbg("after_rst", 4'h5);
      @(posedge clk);
      #1;
      // A write pending while reset is held across an edge is dropped.
      drive(4'h3, 4'hF, 4'h6, 1'b0, 1'b1, 64'hAA, '0);
      rst = 1'b1;
      step_commit();
      test_dbg("rst_blocks", 4'h6);
      rst = 1'b0;
      step_commit();
      wb_en = 1'b0;
      test_dbg("rst_release", 4'h6);
   endtask

   task automatic test_undefined();
      drive(4'h3, 4'hF, 4'h1, 1'b0, 1'b1, 64'hCAFE, '0);
      step_commit();
      drive(4'hD, 4'h1, 4'h6, 1'b1, 1'b1, 64'h999, 64'h888);
      push_decode();
      test_decode_block("undef");
      step_commit();
      wb_en = 1'b0;
      for (int i = 0; i < 15; i++) test_dbg("undef", 4'(i));
   endtask

   // Random traffic over every icode. Reads are checked before each edge
   // against the pre-edge model, so a bypass or early write shows up here.
   task automatic test_back_to_back();
      for (int n = 0; n < 60; n++) begin
         drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) != 0),
               {32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)});
         push_decode();
         test_decode_block("rand");
         step_commit();
         test_dbg("rand", 4'($urandom_range(0, 15)));
      end
      wb_en = 1'b0;
   endtask

   // ---------------- sequence and final report ----------------
   initial begin
      test_reset();
      test_irmovq();
      test_cmov();
      test_push_pop();
      test_wb_en_and_reset();
      test_undefined();
      test_back_to_back();
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
